// File: rtl/rle_run_sched.sv
// Buffers byte codewords and expands (count, symbol) pairs into count beats of symbol; two cycles of pair fetch, then one beat per cycle.
// Back-pressure: stackFull stalls the front end when the FIFO is full; outReady low holds the current beat stable.
module rle_run_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          tclk,
    input  logic          rst,
    input  logic [7:0]    codeWord,
    input  logic          valid,
    input  logic          frameStart,
    output logic          stackFull,
    output logic [7:0]    outData,
    output logic          outValid,
    input  logic          outReady,
    output logic          runDone,
    output logic          overflow,
    output logic [AW:0]   level
);

    typedef enum logic [1:0] {
        S_CNT  = 2'd0,
        S_SYM  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     mem_q [DEPTH];
    logic [7:0]     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     sym_q, sym_d;
    logic [7:0]     rem_q, rem_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;

    logic           full;
    logic           push;
    logic           pop;
    logic           hs;
    logic [7:0]     head;

    always_comb begin
        full = (level_q == (AW+1)'(DEPTH));
        push = valid & ~full;
        pop  = (state_q != S_EMIT) && (level_q != '0);
        hs   = out_valid_q & outReady;
        head = mem_q[rd_ptr_q];

        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        sym_d       = sym_q;
        rem_d       = rem_q;
        overflow_d  = overflow_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (frameStart) begin
            // Flush wins over any same-cycle push or pop; outData keeps its last value.
            state_d     = S_CNT;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            cnt_d       = '0;
            sym_d       = '0;
            rem_d       = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (valid && full) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                mem_d[wr_ptr_q] = codeWord;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (!push && pop) begin
                level_d = level_q - 1'b1;
            end

            case (state_q)
                S_CNT: begin
                    if (pop) begin
                        cnt_d   = head;
                        state_d = S_SYM;
                    end
                end
                S_SYM: begin
                    if (pop) begin
                        sym_d = head;
                        if (cnt_q == 8'd0) begin
                            state_d = S_CNT;
                        end else begin
                            rem_d       = cnt_q;
                            out_data_d  = head;
                            out_valid_d = 1'b1;
                            state_d     = S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    // Entered only with rem_q >= 1, so the decrement cannot wrap.
                    if (hs) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == 8'd1) begin
                            out_valid_d = 1'b0;
                            state_d     = S_CNT;
                        end
                    end
                end
                default: begin
                    state_d     = S_CNT;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge tclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CNT;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            sym_q       <= '0;
            rem_q       <= '0;
            overflow_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            rem_q       <= rem_d;
            overflow_q  <= overflow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign stackFull = full;
    assign outData   = out_data_q;
    assign outValid  = out_valid_q;
    assign runDone   = hs && (rem_q == 8'd1);
    assign overflow  = overflow_q;
    assign level     = level_q;

endmodule

// File: tb/tb_rle_run_sched.sv
// Bench for rle_run_sched: directed scenarios plus a randomized run checked against a pair-expansion model.
module tb_rle_run_sched;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          tclk = 1'b0;
    logic          rst;
    logic [7:0]    codeWord;
    logic          valid;
    logic          frameStart;
    logic          stackFull;
    logic [7:0]    outData;
    logic          outValid;
    logic          outReady;
    logic          runDone;
    logic          overflow;
    logic [AW:0]   level;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_dat[$];
    bit         got_done[$];
    logic [7:0] in_bytes[$];
    logic [7:0] exp_dat[$];
    bit         exp_done[$];

    rle_run_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
        .tclk       (tclk),
        .rst        (rst),
        .codeWord   (codeWord),
        .valid      (valid),
        .frameStart (frameStart),
        .stackFull  (stackFull),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady),
        .runDone    (runDone),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 tclk = ~tclk;

    // Accepted beats are captured mid-cycle, away from the active edge.
    always @(negedge tclk) begin
        if (!rst && outValid && outReady) begin
            got_dat.push_back(outData);
            got_done.push_back(runDone);
        end
    end

    task automatic tick();
        @(posedge tclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        valid    = 1'b1;
        codeWord = b;
        tick();
        valid    = 1'b0;
    endtask

    task automatic clear_streams();
        got_dat.delete();
        got_done.delete();
        in_bytes.delete();
        exp_dat.delete();
        exp_done.delete();
    endtask

    // Reference: each (count, symbol) pair becomes count copies of symbol, last one flagged.
    task automatic build_expected();
        exp_dat.delete();
        exp_done.delete();
        for (int i = 0; i + 1 < in_bytes.size(); i += 2) begin
            for (int k = 0; k < int'(in_bytes[i]); k++) begin
                exp_dat.push_back(in_bytes[i+1]);
                exp_done.push_back(k == int'(in_bytes[i]) - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; codeWord = '0; frameStart = 1'b0; outReady = 1'b0;
        #2;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b expected 0", outValid); end
        checks++; if (outData !== 8'h00) begin errors++; $display("FAIL reset_outData: got %h expected 00", outData); end
        checks++; if (runDone !== 1'b0) begin errors++; $display("FAIL reset_runDone: got %b expected 0", runDone); end
        checks++; if (stackFull !== 1'b0) begin errors++; $display("FAIL reset_stackFull: got %b expected 0", stackFull); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        idle(3);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic(input string tag);
        clear_streams();
        outReady = 1'b1;
        in_bytes = '{8'h03, 8'h41};
        build_expected();
        push_byte(8'h03);
        push_byte(8'h41);
        idle(8);
        checks++; if (got_dat.size() !== exp_dat.size()) begin errors++; $display("FAIL %s_len: got %0d expected %0d", tag, got_dat.size(), exp_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            checks++;
            if ({got_dat[i], got_done[i]} !== {exp_dat[i], exp_done[i]}) begin
                errors++; $display("FAIL %s_beat%0d: got %h/%b expected %h/%b", tag, i, got_dat[i], got_done[i], exp_dat[i], exp_done[i]);
            end
        end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL %s_level: got %0d expected 0", tag, level); end
    endtask

    task automatic test_basic_timing();
        int first_cyc;
        int beats;
        outReady = 1'b1;
        push_byte(8'h03);
        push_byte(8'h41);
        // A run of N takes N+2 cycles: outValid rises one edge after the symbol push.
        first_cyc = -1;
        beats = 0;
        for (int c = 0; c < 8; c++) begin
            if (outValid === 1'b1) begin
                if (first_cyc < 0) first_cyc = c;
                beats++;
            end
            tick();
        end
        checks++; if (first_cyc !== 1) begin errors++; $display("FAIL basic_latency: got %0d expected 1", first_cyc); end
        checks++; if (beats !== 3) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 3", beats); end
    endtask

    task automatic test_backpressure();
        int waited;
        clear_streams();
        outReady = 1'b0;
        in_bytes = '{8'h02, 8'h11};
        push_byte(8'h02);
        push_byte(8'h11);
        tick();
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL bp_emit: got %b expected 1", outValid); end
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = (i % 2 == 0) ? 8'h01 : 8'hAA;
            in_bytes.push_back(b);
            push_byte(b);
        end
        checks++; if (stackFull !== 1'b1) begin errors++; $display("FAIL bp_full: got %b expected 1", stackFull); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL bp_level_full: got %0d expected 8", level); end
        push_byte(8'hEE);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL bp_level_drop: got %0d expected 8", level); end
        outReady = 1'b1;
        waited = 0;
        while (stackFull === 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checks++; if (stackFull !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0 after %0d cycles", stackFull, waited); end
        checks++; if (level !== 4'd7) begin errors++; $display("FAIL bp_level_after_pop: got %0d expected 7", level); end
        idle(30);
        build_expected();
        checks++; if (got_dat.size() !== exp_dat.size()) begin errors++; $display("FAIL bp_len: got %0d expected %0d", got_dat.size(), exp_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            checks++;
            if ({got_dat[i], got_done[i]} !== {exp_dat[i], exp_done[i]}) begin
                errors++; $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", i, got_dat[i], got_done[i], exp_dat[i], exp_done[i]);
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_flush();
        clear_streams();
        outReady = 1'b0;
        push_byte(8'h05);
        push_byte(8'h33);
        tick();
        outReady = 1'b1;
        idle(2);
        outReady = 1'b0;
        push_byte(8'h77);
        push_byte(8'h88);
        checks++; if (got_dat.size() !== 2) begin errors++; $display("FAIL flush_pre_beats: got %0d expected 2", got_dat.size()); end
        checks++; if (level !== 4'd2) begin errors++; $display("FAIL flush_pre_level: got %0d expected 2", level); end
        frameStart = 1'b1;
        valid      = 1'b1;
        codeWord   = 8'h99;
        tick();
        frameStart = 1'b0;
        valid      = 1'b0;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_outValid: got %b expected 0", outValid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b expected 0", overflow); end
        clear_streams();
        outReady = 1'b1;
        in_bytes = '{8'h01, 8'h44};
        build_expected();
        push_byte(8'h01);
        push_byte(8'h44);
        idle(6);
        checks++; if (got_dat.size() !== exp_dat.size()) begin errors++; $display("FAIL flush_post_len: got %0d expected %0d", got_dat.size(), exp_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            checks++;
            if ({got_dat[i], got_done[i]} !== {exp_dat[i], exp_done[i]}) begin
                errors++; $display("FAIL flush_post_beat%0d: got %h/%b expected %h/%b", i, got_dat[i], got_done[i], exp_dat[i], exp_done[i]);
            end
        end
    endtask

    task automatic test_zero_count();
        int dones;
        clear_streams();
        outReady = 1'b1;
        in_bytes = '{8'h00, 8'h55, 8'h02, 8'h66};
        build_expected();
        for (int i = 0; i < in_bytes.size(); i++) push_byte(in_bytes[i]);
        idle(10);
        dones = 0;
        foreach (got_done[i]) if (got_done[i]) dones++;
        checks++; if (dones !== 1) begin errors++; $display("FAIL zero_rundone_count: got %0d expected 1", dones); end
        checks++; if (got_dat.size() !== exp_dat.size()) begin errors++; $display("FAIL zero_len: got %0d expected %0d", got_dat.size(), exp_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            checks++;
            if ({got_dat[i], got_done[i]} !== {exp_dat[i], exp_done[i]}) begin
                errors++; $display("FAIL zero_beat%0d: got %h/%b expected %h/%b", i, got_dat[i], got_done[i], exp_dat[i], exp_done[i]);
            end
        end
    endtask

    task automatic test_sink_stall();
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        clear_streams();
        outReady = 1'b0;
        in_bytes = '{8'h04, 8'h7A};
        build_expected();
        push_byte(8'h04);
        push_byte(8'h7A);
        tick();
        for (int i = 0; i < 7; i++) begin
            outReady = pat[i];
            checks++;
            if ({outValid, outData} !== {1'b1, 8'h7A}) begin
                errors++; $display("FAIL stall_hold%0d: got %b/%h expected 1/7a", i, outValid, outData);
            end
            tick();
        end
        outReady = 1'b1;
        idle(3);
        checks++; if (got_dat.size() !== exp_dat.size()) begin errors++; $display("FAIL stall_len: got %0d expected %0d", got_dat.size(), exp_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            checks++;
            if ({got_dat[i], got_done[i]} !== {exp_dat[i], exp_done[i]}) begin
                errors++; $display("FAIL stall_beat%0d: got %h/%b expected %h/%b", i, got_dat[i], got_done[i], exp_dat[i], exp_done[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_streams();
        outReady = 1'b0;
        push_byte(8'h03);
        push_byte(8'h41);
        tick();
        push_byte(8'h09);
        checks++; if ({outValid, level} !== {1'b1, 4'd1}) begin errors++; $display("FAIL areset_pre: got %b/%0d expected 1/1", outValid, level); end
        outReady = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL areset_outValid: got %b expected 0", outValid); end
        checks++; if (runDone !== 1'b0) begin errors++; $display("FAIL areset_runDone: got %b expected 0", runDone); end
        checks++; if (stackFull !== 1'b0) begin errors++; $display("FAIL areset_stackFull: got %b expected 0", stackFull); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL areset_level: got %0d expected 0", level); end
        tick();
        rst = 1'b0;
        idle(1);
        test_basic("post_reset");
    endtask

    task automatic test_random();
        int idx;
        int budget;
        clear_streams();
        for (int p = 0; p < 20; p++) begin
            in_bytes.push_back(8'($urandom_range(0, 4)));
            in_bytes.push_back(8'($urandom));
        end
        build_expected();
        idx = 0;
        budget = 0;
        while (budget < 4000 && !(idx == in_bytes.size() && got_dat.size() >= exp_dat.size() && level == 0)) begin
            outReady = ($urandom_range(0, 9) < 7);
            if (idx < in_bytes.size() && stackFull === 1'b0 && $urandom_range(0, 1) == 1) begin
                valid    = 1'b1;
                codeWord = in_bytes[idx];
                idx++;
            end else begin
                valid = 1'b0;
            end
            tick();
            budget++;
        end
        valid    = 1'b0;
        outReady = 1'b1;
        idle(5);
        checks++; if (budget >= 4000) begin errors++; $display("FAIL rand_timeout: got %0d cycles expected < 4000", budget); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rand_level: got %0d expected 0", level); end
        checks++; if (got_dat.size() !== exp_dat.size()) begin errors++; $display("FAIL rand_len: got %0d expected %0d", got_dat.size(), exp_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            checks++;
            if ({got_dat[i], got_done[i]} !== {exp_dat[i], exp_done[i]}) begin
                errors++; $display("FAIL rand_beat%0d: got %h/%b expected %h/%b", i, got_dat[i], got_done[i], exp_dat[i], exp_done[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_basic_timing();
        test_backpressure();
        test_flush();
        test_zero_count();
        test_sink_stall();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rle_run_sched.md
Name: rle_run_sched

Overview:
- Sits between the serial-to-parallel front end and the RLE output sink.
- Accepts byte codewords, buffers them in an internal FIFO and asserts stackFull as back-pressure to the front end.
- Pairs buffered bytes into (run count, symbol) and emits the symbol count times over a valid/ready output handshake.
- The frame-start flag from the front end resynchronises the block.

Parameters:
- DEPTH, 8, FIFO depth in bytes; must be a power of 2 and at least 2.
- AW, 3, log2(DEPTH); FIFO pointer width.

Ports:
- tclk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- codeWord  in  8  byte from front end.
- valid  in  1  codeWord present this cycle.
- frameStart  in  1  synchronous flush, driven by the front end's start-pattern flag.
- stackFull  out  1  FIFO full; front end must stall.
- outData  out  8  decoded symbol.
- outValid  out  1  outData valid.
- outReady  in  1  sink accepts outData.
- runDone  out  1  marks the last symbol of a run; combinational, equals outValid & outReady on the final beat.
- overflow  out  1  sticky: a byte arrived while full.
- level  out  AW+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset values: outValid=0, outData=0, runDone=0, stackFull=0, overflow=0, level=0. FSM=S_CNT. FIFO pointers, cntReg, symReg and remaining are all 0.
- Push rule: push = valid & ~full.
  - A byte offered while full is dropped, sets overflow, and does not change level.
- stackFull = (level==DEPTH). It is decoded from registered level, with no combinational path from valid.
- Pop rule: a pop happens only in S_CNT or S_SYM when level!=0.
  - Pop data is the FIFO head, captured at the clock edge.
  - There is no empty bypass: a push into an empty FIFO is not poppable until the next cycle.
- Simultaneous push and pop: level is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- frameStart has priority over everything except rst. On a frameStart cycle:
  - Pointers, level, cntReg, symReg, remaining and overflow are cleared; FSM goes to S_CNT; outValid drops next cycle.
  - A push or pop in the same cycle is ignored.
- FSM:
  - S_CNT: if level!=0, pop into cntReg and go to S_SYM. Otherwise hold.
  - S_SYM: if level!=0, pop into symReg. Then:
    - if cntReg==0, discard the pair (no output) and go to S_CNT;
    - otherwise set remaining=cntReg and go to S_EMIT.
    - If level==0, hold.
  - S_EMIT: outValid=1, outData=symReg.
    - On outValid & outReady, remaining decrements.
    - If remaining==1 at the handshake, runDone=1 that cycle and FSM goes to S_CNT.
    - outData is held stable while outValid=1 & outReady=0.
- Outside S_EMIT: outValid=0. outData holds its last value (0 after reset).
- Throughput:
  - Minimum 2 cycles of pair fetch, then one symbol per cycle while outReady=1.
  - A run of N costs N+2 cycles with no stalls.
  - The FIFO continues to accept pushes during S_EMIT.
- Run length is unsigned 8-bit, 1..255. A count of 0 means an empty run.
- Counter arithmetic is 8-bit; remaining never underflows because S_EMIT is entered only with remaining>=1.
- Reset mid-run: all state clears asynchronously; the partial run is lost; outputs go low immediately.

Test Plan:
- Basic run: push 0x03, 0x41 (valid one cycle each), outReady=1 -> outData=0x41 with outValid for exactly 3 consecutive cycles; runDone on the 3rd; level back to 0.
- Back-pressure: push 8 bytes with outReady=0 and the FSM stalled in S_EMIT -> stackFull=1 after the 8th push. A 9th valid is dropped and overflow=1. Raise outReady -> stackFull drops after the first pop.
- Zero count: push 0x00, 0x55, 0x02, 0x66 -> no 0x55 emitted; 0x66 emitted twice; runDone once.
- Sink stall: run 0x04, 0x7A with outReady toggling 1,0,0,1,1,0,1 -> exactly 4 accepted beats; outData stays 0x7A throughout; runDone only on the 4th handshake.
- Flush mid-run: 0x05, 0x33 with 2 symbols accepted, plus 2 bytes queued; pulse frameStart -> outValid=0 next cycle, level=0, overflow=0. A new pair 0x01, 0x44 then emits 0x44 once.
- Async reset mid-emit: assert rst between clock edges during S_EMIT -> outValid, runDone, stackFull and level go to 0 without waiting for tclk. Post-reset operation matches the basic-run case.
